// File: rtl/vga_pkg.sv
// Shared definitions for the snake VGA subsystem.
//   - board RAM geometry (32x24 tiles, 10-bit address, 4-bit tile code)
//   - game-step period width and counter width
//   - scheduler FSM state encoding
//   - clamp_period(): a period of 0 is treated as 1
package vga_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 4;
  localparam int BOARD_COLS  = 32;
  localparam int BOARD_ROWS  = 24;
  localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;
  localparam int PERIOD_W    = 6;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } sched_state_e;

  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame divider for the vblank step scheduler.
// Detects vblank rising edges, counts frames and divides the frame rate
// down to the programmable game-step rate.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   i_vblank       vertical blanking level (synchronous to clk)
//   i_pause        while high no step becomes due; divider saturates
//   i_load         a step is being issued: latch i_period_in
//   i_period_in    frames per step (0 treated as 1)
//   o_vb_rise      vblank rising-edge pulse
//   o_step_due     vb_rise on which a step is due
//   o_frame_cnt    number of vblank rising edges (wraps)
module frame_divider
  import vga_pkg::*;
#(
  parameter int DEFAULT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vblank,
  input  logic                i_pause,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_period_in,
  output logic                o_vb_rise,
  output logic                o_step_due,
  output logic [CNT_W-1:0]    o_frame_cnt
);

  logic                r_vb_d;
  logic [PERIOD_W-1:0] r_div;
  logic [PERIOD_W-1:0] r_period;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic                w_vb_rise;
  logic [PERIOD_W:0]   w_div_inc;
  logic                w_at_end;

  assign w_vb_rise = i_vblank & ~r_vb_d;
  // One extra bit so div+1 cannot wrap; >= keeps the divider safe even if
  // it ever sits above the period.
  assign w_div_inc = {1'b0, r_div} + 1'b1;
  assign w_at_end  = (w_div_inc >= {1'b0, r_period});

  assign o_vb_rise   = w_vb_rise;
  assign o_step_due  = w_vb_rise & w_at_end & ~i_pause;
  assign o_frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb_d      <= 1'b0;
      r_div       <= '0;
      r_period    <= clamp_period(PERIOD_W'(DEFAULT_PERIOD));
      r_frame_cnt <= '0;
    end else begin
      r_vb_d <= i_vblank;
      if (w_vb_rise) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        if (w_at_end) begin
          // Paused: park one tick before the end so the first unpaused
          // vb_rise fires immediately.
          r_div <= i_pause ? (r_period - 1'b1) : '0;
        end else begin
          r_div <= w_div_inc[PERIOD_W-1:0];
        end
      end
      if (i_load) begin
        r_period <= clamp_period(i_period_in);
      end
    end
  end

endmodule

// File: rtl/vblank_step_scheduler.sv
// Vblank step scheduler: issues game-step requests at a programmable
// number of frames per step and arbitrates the single-port board RAM
// between the pixel renderer (default owner) and the game logic (only
// during blanking while a step is in progress).
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   vblank, pause, period_in      frame timing and step-rate control
//   step_start / step_done        one-cycle handshake pulses with game FSM
//   gm_req/we/addr/wdata          game RAM access request
//   gm_gnt, gm_rvalid, gm_rdata   game RAM grant and read return
//   rd_addr / rd_data             renderer read port (1-cycle latency)
//   mem_addr/we/wdata/rdata       board RAM port
//   frame_cnt, step_cnt, overrun  status
// Game access handshake: a request is accepted in any cycle where gm_req
// and gm_gnt are both high; otherwise the game must hold the request
// unchanged. Accepted reads return gm_rvalid exactly one cycle later.
module vblank_step_scheduler #(
  parameter int ADDR_W         = vga_pkg::ADDR_W,
  parameter int DATA_W         = vga_pkg::DATA_W,
  parameter int DEFAULT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              pause,
  input  logic [5:0]        period_in,
  output logic              step_start,
  input  logic              step_done,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_gnt,
  output logic              gm_rvalid,
  output logic [DATA_W-1:0] gm_rdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       step_cnt,
  output logic              overrun
);

  import vga_pkg::*;

  sched_state_e     r_state;
  logic             r_step_start;
  logic             r_gm_rvalid;
  logic             r_overrun;
  logic [CNT_W-1:0] r_step_cnt;

  logic             w_vb_rise;
  logic             w_step_due;
  logic             w_issue;
  logic             w_gnt;

  // A due step is only issued from IDLE; otherwise it is dropped, so at
  // most one step is ever outstanding.
  assign w_issue = w_step_due & (r_state == IDLE);

  frame_divider #(
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_frame_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vblank    (vblank),
    .i_pause     (pause),
    .i_load      (w_issue),
    .i_period_in (period_in),
    .o_vb_rise   (w_vb_rise),
    .o_step_due  (w_step_due),
    .o_frame_cnt (frame_cnt)
  );

  // Grant is gated by the live vblank level so the game loses the RAM in
  // the very cycle blanking ends, before the FSM has moved to STALL.
  assign w_gnt = (r_state == RUN) & vblank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_step_start <= 1'b0;
      r_gm_rvalid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_step_cnt   <= '0;
    end else begin
      r_step_start <= 1'b0;
      r_gm_rvalid  <= w_gnt & gm_req & ~gm_we;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state      <= RUN;
            r_step_start <= 1'b1;
            r_step_cnt   <= r_step_cnt + 1'b1;
          end
        end
        RUN: begin
          // step_done wins over the end of blanking: no overrun then.
          if (step_done) begin
            r_state <= IDLE;
          end else if (!vblank) begin
            r_state   <= STALL;
            r_overrun <= 1'b1;
          end
        end
        STALL: begin
          if (step_done) begin
            r_state <= IDLE;
          end else if (w_vb_rise) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign step_start = r_step_start;
  assign gm_gnt     = w_gnt;
  assign gm_rvalid  = r_gm_rvalid;
  assign overrun    = r_overrun;
  assign step_cnt   = r_step_cnt;

  assign mem_addr  = w_gnt ? gm_addr : rd_addr;
  assign mem_we    = w_gnt & gm_req & gm_we;
  assign mem_wdata = w_gnt ? gm_wdata : '0;
  assign rd_data   = mem_rdata;
  assign gm_rdata  = mem_rdata;

endmodule

// File: tb/tb_vblank_step_scheduler.sv
module tb_vblank_step_scheduler;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int ACT    = 6;
  localparam int BLANK  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              vblank = 1'b0;
  logic              pause = 1'b0;
  logic [5:0]        period_in = 6'd4;
  logic              step_start;
  logic              step_done = 1'b0;
  logic              gm_req = 1'b0;
  logic              gm_we = 1'b0;
  logic [ADDR_W-1:0] gm_addr = '0;
  logic [DATA_W-1:0] gm_wdata = '0;
  logic              gm_gnt;
  logic              gm_rvalid;
  logic [DATA_W-1:0] gm_rdata;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       frame_cnt;
  logic [15:0]       step_cnt;
  logic              overrun;

  vblank_step_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEFAULT_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .pause(pause),
    .period_in(period_in), .step_start(step_start), .step_done(step_done),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .frame_cnt(frame_cnt), .step_cnt(step_cnt), .overrun(overrun)
  );

  // synchronous board RAM model, one-cycle read latency
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q = '0;
  assign mem_rdata = ram_q;
  initial for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_q <= ram[mem_addr];
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0]          exp_step_q[$];  // {step_cnt, frame_cnt} at step_start
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];  // {mem_addr, mem_wdata} at mem_we
  logic [DATA_W-1:0]    exp_rd_q[$];    // gm_rdata at gm_rvalid
  logic saw_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    forever begin
      @(negedge clk);
      if (step_start) begin
        saw_start = 1'b1;
        if (exp_step_q.size() == 0) chk("unexpected_step_start", {step_cnt, frame_cnt}, 32'hFFFF_FFFF);
        else chk("step_start_counts", {step_cnt, frame_cnt}, exp_step_q.pop_front());
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) chk("unexpected_mem_we", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
        else chk("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
      end
      if (gm_rvalid) begin
        if (exp_rd_q.size() == 0) chk("unexpected_gm_rvalid", 32'(gm_rdata), 32'hFFFF_FFFF);
        else chk("gm_rdata", 32'(gm_rdata), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  // one frame: ACT cycles of active video then BLANK cycles of blanking;
  // step_done pulses at blank cycle done_at if a step was seen (done_at < BLANK)
  task automatic frame(input int done_at);
    vblank = 1'b0;
    repeat (ACT) cyc();
    vblank = 1'b1;
    for (int i = 1; i < BLANK; i++) begin
      cyc();
      step_done = (i == done_at) && saw_start;
      if (step_done) saw_start = 1'b0;
    end
    cyc();
    step_done = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // ---- reset state ----
    repeat (3) cyc();
    chk("rst_step_start", 32'(step_start), 0);
    chk("rst_gm_gnt", 32'(gm_gnt), 0);
    chk("rst_gm_rvalid", 32'(gm_rvalid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_step_cnt", 32'(step_cnt), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    cyc();

    // ---- test 1: period 4, 12 frames ----
    exp_step_q.push_back({16'd1, 16'd4});
    exp_step_q.push_back({16'd2, 16'd8});
    exp_step_q.push_back({16'd3, 16'd12});
    repeat (12) frame(4);
    chk("t1_step_cnt", 32'(step_cnt), 3);
    chk("t1_frame_cnt", 32'(frame_cnt), 12);
    chk("t1_overrun", 32'(overrun), 0);

    // ---- test 2: granted write then read in frame 16 ----
    repeat (3) frame(4);
    exp_step_q.push_back({16'd4, 16'd16});
    vblank = 1'b0;
    repeat (ACT) cyc();
    vblank = 1'b1;
    cyc();
    cyc();
    chk("t2_gnt_in_run", 32'(gm_gnt), 1);
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 10'h123; gm_wdata = 4'hA;
    exp_wr_q.push_back({10'h123, 4'hA});
    cyc();
    gm_we = 1'b0;
    exp_rd_q.push_back(4'hA);
    cyc();
    gm_req = 1'b0;
    cyc();
    step_done = 1'b1;
    cyc();
    step_done = 1'b0;
    chk("t2_gnt_after_done", 32'(gm_gnt), 0);
    chk("t2_step_cnt", 32'(step_cnt), 4);
    cyc();
    chk("t2_rvalid_done", 32'(exp_rd_q.size()), 0);

    // ---- test 3: overrun, STALL, resume ----
    repeat (3) frame(4);              // frames 17..19
    exp_step_q.push_back({16'd5, 16'd20});
    frame(-1);                        // frame 20, step never finishes
    vblank = 1'b0;
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 10'h3FF; gm_wdata = 4'h7;
    rd_addr = 10'h123;
    #1;
    chk("t3_gnt_drop_blank_end", 32'(gm_gnt), 0);
    cyc();
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_stall_gnt", 32'(gm_gnt), 0);
    chk("t3_stall_mem_addr", 32'(mem_addr), 32'h123);
    chk("t3_rd_data", 32'(rd_data), 32'hA);
    gm_we = 1'b0;
    repeat (3) cyc();
    gm_req = 1'b0;
    cyc();
    vblank = 1'b1;                    // frame 21
    cyc();
    chk("t3_resume_gnt", 32'(gm_gnt), 1);
    chk("t3_no_new_step", 32'(step_cnt), 5);
    step_done = 1'b1;
    cyc();
    step_done = 1'b0;
    chk("t3_idle_gnt", 32'(gm_gnt), 0);
    chk("t3_overrun_sticky", 32'(overrun), 1);
    saw_start = 1'b0;
    repeat (BLANK - 2) cyc();

    // ---- test 4: pause across 10 frames ----
    pause = 1'b1;
    repeat (10) frame(4);             // frames 22..31
    chk("t4_paused_step_cnt", 32'(step_cnt), 5);
    pause = 1'b0;
    period_in = 6'd0;
    exp_step_q.push_back({16'd6, 16'd32});
    frame(4);                         // frame 32: fires at once, loads period 1
    chk("t4_step_after_pause", 32'(step_cnt), 6);

    // ---- test 5: period 0 -> every frame; 4 -> 2 mid-interval ----
    exp_step_q.push_back({16'd7, 16'd33});
    frame(4);
    period_in = 6'd4;
    exp_step_q.push_back({16'd8, 16'd34});
    frame(4);                         // loads 4
    frame(4);                         // 35
    period_in = 6'd2;                 // must not take effect until next step
    frame(4);                         // 36
    frame(4);                         // 37
    exp_step_q.push_back({16'd9, 16'd38});
    frame(4);                         // 38, loads 2
    frame(4);                         // 39
    exp_step_q.push_back({16'd10, 16'd40});
    frame(4);                         // 40
    chk("t5_step_cnt", 32'(step_cnt), 10);

    // ---- test 6: async reset mid-RUN ----
    frame(4);                         // 41
    exp_step_q.push_back({16'd11, 16'd42});
    vblank = 1'b0;
    repeat (ACT) cyc();
    vblank = 1'b1;
    cyc();
    cyc();
    chk("t6_gnt_before_rst", 32'(gm_gnt), 1);
    chk("t6_queue_before_rst", 32'(exp_step_q.size()), 0);
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 10'h200; gm_wdata = 4'h5;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gm_gnt), 0);
    chk("t6_rst_mem_we", 32'(mem_we), 0);
    chk("t6_rst_step_start", 32'(step_start), 0);
    chk("t6_rst_overrun", 32'(overrun), 0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("t6_rst_step_cnt", 32'(step_cnt), 0);
    gm_req = 1'b0; gm_we = 1'b0;
    vblank = 1'b0;
    saw_start = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    exp_step_q.push_back({16'd1, 16'd4});
    repeat (4) frame(4);
    chk("t6_step_cnt", 32'(step_cnt), 1);
    chk("t6_frame_cnt", 32'(frame_cnt), 4);
    repeat (3) cyc();

    chk("end_step_q_empty", 32'(exp_step_q.size()), 0);
    chk("end_wr_q_empty", 32'(exp_wr_q.size()), 0);
    chk("end_rd_q_empty", 32'(exp_rd_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
